// File: rtl/weld_pkg.sv
// Shared definitions for the weld monitor: FSM state encoding and default
// parameter values used by the top and the per-channel checker.
package weld_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_MONITOR = 2'b01,
        ST_FAULT   = 2'b10,
        ST_HOLDOFF = 2'b11
    } weld_state_t;

    localparam int DEF_NUM_CH   = 3;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_DEBOUNCE = 3;
    localparam int DEF_HOLD_CYC = 4;
    localparam int DEF_CNT_W    = 32;

    // Wide enough for the largest allowed debounce depth (15).
    localparam int DEB_CNT_W = 4;

endpackage

// File: rtl/weld_ch_check.sv
// One monitored channel: unsigned window compare plus consecutive-violation
// debounce counter; reach flags the cycle whose violation completes the run.
module weld_ch_check
    import weld_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEBOUNCE = DEF_DEBOUNCE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              active,
    input  logic              en,
    input  logic [DATA_W-1:0] sample,
    input  logic [DATA_W-1:0] lo,
    input  logic [DATA_W-1:0] hi,
    output logic              reach
);

    logic [DEB_CNT_W-1:0] count;
    logic                 violating;

    assign violating = en && ((sample < lo) || (sample > hi));
    assign reach     = active && violating && (count == DEB_CNT_W'(DEBOUNCE - 1));

    // The counter restarts after a completed run; the FSM leaves MONITOR then anyway.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (active && violating && !reach) begin
            count <= count + DEB_CNT_W'(1);
        end else begin
            count <= '0;
        end
    end

endmodule

// File: rtl/weld_monitor.sv
// Multi-channel weld window monitor: arm/disarm FSM, debounced trip detection,
// fault latch with operator acknowledge and fixed holdoff before re-arming.
module weld_monitor
    import weld_pkg::*;
#(
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEBOUNCE = DEF_DEBOUNCE,
    parameter int HOLD_CYC = DEF_HOLD_CYC,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     ack,
    input  logic [NUM_CH-1:0]        ch_en,
    input  logic [NUM_CH*DATA_W-1:0] sample,
    input  logic [NUM_CH*DATA_W-1:0] limit_lo,
    input  logic [NUM_CH*DATA_W-1:0] limit_hi,
    output logic                     alarm,
    output logic [1:0]               state,
    output logic [NUM_CH-1:0]        fault_mask,
    output logic [NUM_CH*DATA_W-1:0] last_sample,
    output logic [CNT_W-1:0]         fail_count
);

    localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    weld_state_t       cur_state;
    weld_state_t       nxt_state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [NUM_CH-1:0] reach;
    logic              monitoring;
    logic              trip;

    assign monitoring = (cur_state == ST_MONITOR);
    assign trip       = monitoring && (|reach);
    assign state      = cur_state;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        weld_ch_check #(
            .DATA_W  (DATA_W),
            .DEBOUNCE(DEBOUNCE)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .active(monitoring),
            .en    (ch_en[i]),
            .sample(sample[i*DATA_W +: DATA_W]),
            .lo    (limit_lo[i*DATA_W +: DATA_W]),
            .hi    (limit_hi[i*DATA_W +: DATA_W]),
            .reach (reach[i])
        );
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            ST_IDLE:    if (start) nxt_state = ST_MONITOR;
            ST_MONITOR: begin
                if (trip)      nxt_state = ST_FAULT;
                else if (stop) nxt_state = ST_IDLE;
            end
            ST_FAULT:   if (ack) nxt_state = ST_HOLDOFF;
            ST_HOLDOFF: if (hold_cnt == HOLD_W'(HOLD_CYC - 1)) nxt_state = ST_IDLE;
            default:    nxt_state = ST_IDLE;
        endcase
    end

    // Alarm is registered from the next state so it is high exactly while in FAULT.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state   <= ST_IDLE;
            alarm       <= 1'b0;
            fault_mask  <= '0;
            last_sample <= '0;
            fail_count  <= '0;
            hold_cnt    <= '0;
        end else begin
            cur_state <= nxt_state;
            alarm     <= (nxt_state == ST_FAULT);
            if (monitoring) begin
                last_sample <= sample;
            end
            if (trip) begin
                fault_mask <= reach;
                if (fail_count != {CNT_W{1'b1}}) begin
                    fail_count <= fail_count + CNT_W'(1);
                end
            end
            if (cur_state == ST_HOLDOFF) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end else begin
                hold_cnt <= '0;
            end
        end
    end

endmodule
